// File: rtl/led_fader_pkg.sv
// Shared types and elaboration-time helpers for the LED fader.
//   fader_state_t  : fade FSM encoding
//   clog2          : ceiling log2
//   counter_width  : clog2 with a one-bit floor, for prescaler widths
//   slot_clks      : clocks per PWM slot, at least 1
//   step_clks      : clocks per duty step during a fade, at least 1
package led_fader_pkg;

  typedef enum logic [1:0] {
    StOff,
    StRise,
    StOn,
    StFall
  } fader_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  function automatic int unsigned counter_width(input int unsigned count);
    int unsigned w = clog2(count);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned slot_clks(input int unsigned clk_freq_khz,
                                            input int unsigned pwm_freq_hz,
                                            input int unsigned duty_w);
    longint unsigned num = 64'(clk_freq_khz) * 64'd1000;
    longint unsigned den = 64'(pwm_freq_hz) << duty_w;
    longint unsigned q   = num / den;
    return (q == 0) ? 1 : 32'(q);
  endfunction

  function automatic int unsigned step_clks(input int unsigned fade_ms,
                                            input int unsigned clk_freq_khz,
                                            input int unsigned duty_w);
    longint unsigned max_duty = (64'd1 << duty_w) - 64'd1;
    longint unsigned q        = (64'(fade_ms) * 64'(clk_freq_khz)) / max_duty;
    return (q == 0) ? 1 : 32'(q);
  endfunction

endpackage

// File: rtl/led_fader_pwm_core.sv
// PWM generator: free-running slot prescaler and slot counter, compared
// against the requested duty to produce a registered pin drive.
//   clk, rst : clock, synchronous active-high reset
//   duty     : duty level, 0 = always low, all-ones = always high
//   en       : output enable, 0 forces pwm_out low
//   pwm_out  : registered PWM output
module led_pwm_core
  import led_fader_pkg::*;
#(
  parameter int unsigned DUTY_W    = 8,
  parameter int unsigned SLOT_CLKS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty,
  input  logic              en,
  output logic              pwm_out
);

  localparam int unsigned       PreW    = counter_width(SLOT_CLKS);
  localparam logic [PreW-1:0]   PreLast = PreW'(SLOT_CLKS - 1);
  localparam logic [DUTY_W-1:0] MaxDuty = '1;

  logic [PreW-1:0]   pre_q, pre_d;
  logic [DUTY_W-1:0] slot_q, slot_d;
  logic              pwm_q, pwm_d;

  always_comb begin
    pre_d  = pre_q + 1'b1;
    slot_d = slot_q;
    if (pre_q == PreLast) begin
      pre_d  = '0;
      slot_d = slot_q + 1'b1;
    end
    // Full duty is forced high so there is no one-slot gap at the frame end.
    pwm_d = en & ((duty == MaxDuty) | (slot_q < duty));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      slot_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      slot_q <= slot_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/led_fader.sv
// LED fader: ramps the PWM duty linearly towards full on while led_req is
// high and towards off while it is low, and drives the LED pin with PWM.
//   clk, rst : clock, synchronous active-high reset
//   led_req  : on request from the blinker
//   en       : output enable; 0 forces pwm_out low, the fade keeps running
//   pwm_out  : registered PWM pin drive
//   duty     : current duty level (registered)
//   busy     : high while a fade is in progress
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned CLK_FREQ_KHz = 50000,
  parameter int unsigned PWM_FREQ_Hz  = 1000,
  parameter int unsigned DUTY_W       = 8,
  parameter int unsigned FADE_MS      = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              led_req,
  input  logic              en,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty,
  output logic              busy
);

  localparam int unsigned       SlotClks = slot_clks(CLK_FREQ_KHz, PWM_FREQ_Hz, DUTY_W);
  localparam int unsigned       StepClks = step_clks(FADE_MS, CLK_FREQ_KHz, DUTY_W);
  localparam int unsigned       StepW    = counter_width(StepClks);
  localparam logic [StepW-1:0]  StepLast = StepW'(StepClks - 1);
  localparam logic [DUTY_W-1:0] MaxDuty  = '1;

  fader_state_t      state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [StepW-1:0]  step_q, step_d;
  logic              busy_q, busy_d;
  logic              step_tick;

  // The prescaler only leaves 0 in StRise/StFall, so a tick implies a ramp.
  assign step_tick = (step_q == StepLast);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    step_d  = step_q;
    unique case (state_q)
      StOff: begin
        step_d = '0;
        if (led_req) state_d = StRise;
      end
      StRise: begin
        step_d = step_tick ? '0 : step_q + 1'b1;
        // A reversal holds duty and keeps the prescaler phase, so the
        // direction change is seamless; it wins over a coincident tick.
        if (!led_req) begin
          state_d = StFall;
        end else if (step_tick) begin
          if (duty_q != MaxDuty) duty_d = duty_q + 1'b1;
          if (duty_d == MaxDuty) begin
            state_d = StOn;
            step_d  = '0;
          end
        end
      end
      StOn: begin
        step_d = '0;
        if (!led_req) state_d = StFall;
      end
      StFall: begin
        step_d = step_tick ? '0 : step_q + 1'b1;
        if (led_req) begin
          state_d = StRise;
        end else if (step_tick) begin
          if (duty_q != '0) duty_d = duty_q - 1'b1;
          if (duty_d == '0) begin
            state_d = StOff;
            step_d  = '0;
          end
        end
      end
      default: begin
        state_d = StOff;
        step_d  = '0;
      end
    endcase
    busy_d = (state_d == StRise) || (state_d == StFall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOff;
      duty_q  <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  led_pwm_core #(
    .DUTY_W   (DUTY_W),
    .SLOT_CLKS(SlotClks)
  ) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .duty   (duty_q),
    .en     (en),
    .pwm_out(pwm_out)
  );

  assign duty = duty_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;

  // Test configuration: slot = 2 clocks, step = 2 clocks, max duty 15.
  localparam int Slot   = 2;
  localparam int Step   = 2;
  localparam int MaxD   = 15;
  localparam int MOff   = 0;
  localparam int MRise  = 1;
  localparam int MOn    = 2;
  localparam int MFall  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       led_req = 1'b0;
  logic       en = 1'b1;
  logic       pwm_out;
  logic [3:0] duty;
  logic       busy;

  led_fader #(
    .CLK_FREQ_KHz(1),
    .PWM_FREQ_Hz (31),
    .DUTY_W      (4),
    .FADE_MS     (30)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .led_req(led_req),
    .en     (en),
    .pwm_out(pwm_out),
    .duty   (duty),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int busy;
    int pwm;
  } exp_t;

  typedef struct {
    logic r;
    logic q;
    logic e;
    int   cycles;
    int   exp_duty;
    int   exp_busy;
    int   exp_pwm;  // -1: not checked at this point
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc_n = 0;

  // Reference model state.
  int m_state, m_duty, m_step, m_pre, m_slot, m_pwm, m_busy;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic q, input logic e);
    bit tick;
    exp_t x;
    if (r) begin
      m_state = MOff; m_duty = 0; m_step = 0; m_pre = 0; m_slot = 0;
      m_pwm = 0; m_busy = 0;
    end else begin
      m_pwm = (e && (m_duty == MaxD || m_slot < m_duty)) ? 1 : 0;
      if (m_pre == Slot - 1) begin
        m_pre  = 0;
        m_slot = (m_slot + 1) % (MaxD + 1);
      end else begin
        m_pre++;
      end
      tick = (m_state == MRise || m_state == MFall) && (m_step == Step - 1);
      case (m_state)
        MOff: if (q) m_state = MRise;
        MOn:  if (!q) m_state = MFall;
        MRise: begin
          m_step = tick ? 0 : m_step + 1;
          if (!q) m_state = MFall;
          else if (tick) begin
            if (m_duty < MaxD) m_duty++;
            if (m_duty == MaxD) begin m_state = MOn; m_step = 0; end
          end
        end
        default: begin
          m_step = tick ? 0 : m_step + 1;
          if (q) m_state = MRise;
          else if (tick) begin
            if (m_duty > 0) m_duty--;
            if (m_duty == 0) begin m_state = MOff; m_step = 0; end
          end
        end
      endcase
      m_busy = (m_state == MRise || m_state == MFall) ? 1 : 0;
    end
    x.duty = m_duty;
    x.busy = m_busy;
    x.pwm  = m_pwm;
    sb_q.push_back(x);
  endtask

  // One clock: drive inputs, predict, then compare just after the edge.
  task automatic cyc(input logic r, input logic q, input logic e);
    exp_t x;
    rst = r; led_req = q; en = e;
    model_step(r, q, e);
    @(posedge clk);
    #1;
    cyc_n++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      x = sb_q.pop_front();
      check("sb_duty", int'(duty), x.duty);
      check("sb_busy", int'(busy), x.busy);
      check("sb_pwm", int'(pwm_out), x.pwm);
    end
  endtask

  vec_t vecs[9];
  int   hi;
  bit   hit;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1,  3,  0, 0,  0};  // reset with led_req held
    vecs[1] = '{1'b0, 1'b1, 1'b1,  1,  0, 1,  0};  // RISE one cycle after release
    vecs[2] = '{1'b0, 1'b1, 1'b1, 29, 14, 1, -1};
    vecs[3] = '{1'b0, 1'b1, 1'b1,  1, 15, 0, -1};  // 30 clocks of ramp -> ON
    vecs[4] = '{1'b0, 1'b1, 1'b1,  2, 15, 0,  1};
    vecs[5] = '{1'b0, 1'b1, 1'b0,  1, 15, 0,  0};  // en gating
    vecs[6] = '{1'b0, 1'b1, 1'b1,  1, 15, 0,  1};
    vecs[7] = '{1'b0, 1'b0, 1'b1,  1, 15, 1,  1};  // ON -> FALL
    vecs[8] = '{1'b0, 1'b0, 1'b1,  2, 14, 1, -1};

    for (int v = 0; v < 9; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) cyc(vecs[v].r, vecs[v].q, vecs[v].e);
      check($sformatf("vec%0d_duty", v), int'(duty), vecs[v].exp_duty);
      check($sformatf("vec%0d_busy", v), int'(busy), vecs[v].exp_busy);
      if (vecs[v].exp_pwm >= 0) check($sformatf("vec%0d_pwm", v), int'(pwm_out), vecs[v].exp_pwm);
    end

    // Finish the fall, then a full frame at duty 0 must be all low.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      hit = !busy;
    end
    check("fall_done", int'(hit), 1);
    check("fall_duty0", int'(duty), 0);
    cyc(1'b0, 1'b0, 1'b1);
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      hi += int'(pwm_out);
    end
    check("frame_duty0_high", hi, 0);

    // Reversal at duty 7 during a rise: next change must be down to 6.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      hit = (duty == 4'd7);
    end
    check("reach_duty7", int'(hit), 1);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      hit = (duty != 4'd7);
    end
    check("rev_changed", int'(hit), 1);
    check("rev_duty6", int'(duty), 6);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      hit = !busy;
    end
    check("rev_off", int'(hit), 1);
    check("rev_off_duty", int'(duty), 0);

    // Full rise, then a full frame at duty 15 must be all high.
    cyc(1'b0, 1'b1, 1'b1);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      hit = !busy;
    end
    check("rise_on", int'(hit), 1);
    check("rise_duty15", int'(duty), 15);
    cyc(1'b0, 1'b1, 1'b1);
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      hi += int'(pwm_out);
    end
    check("frame_duty15_high", hi, 32);

    // Reset in the middle of a fall aborts it immediately.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      hit = (duty == 4'd9);
    end
    check("reach_duty9", int'(hit), 1);
    cyc(1'b1, 1'b0, 1'b1);
    check("rstmid_duty", int'(duty), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_pwm", int'(pwm_out), 0);
    cyc(1'b0, 1'b0, 1'b1);
    check("rstmid_off_busy", int'(busy), 0);
    check("rstmid_off_duty", int'(duty), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
